// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Result registers (sum/cout/ovf) update only on entry to DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Handshake: start is a request sampled only in IDLE (never queued); busy is
    // high for the WIDTH cycles of RUN; done is a one-cycle pulse after the last
    // bit, and busy/done are never high together.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, res, res_next;
    logic [CW-1:0]    cnt;
    logic             carry, carry_next, bit_s, last_bit;

    always_comb begin
        bit_s      = op_a[0] ^ op_b[0] ^ carry;
        carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        res_next   = (res >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
        last_bit   = (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            res   <= res_next;
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                // carry still holds the carry into the MSB here
                sum  <= res_next;
                cout <= carry_next;
                ovf  <= carry ^ carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors for WIDTH=8 and WIDTH=1
// plus randomized operations scored against an arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start1, sub1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];
    logic [7:0] last8, last1;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {cout, ovf, sum} from plain w-bit arithmetic and sign rules
    function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic sub);
        int mask, aa, bb, r, cy;
        logic sa, sb, sr, ov;
        mask = (1 << w) - 1;
        aa   = int'(a) & mask;
        bb   = int'(b) & mask;
        if (sub) begin
            r  = (aa - bb) & mask;
            cy = (aa >= bb) ? 1 : 0;
        end else begin
            r  = (aa + bb) & mask;
            cy = (aa + bb) >> w;
        end
        sa = aa[w-1];
        sb = bb[w-1];
        sr = r[w-1];
        ov = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        return {cy[0], ov, r[7:0]};
    endfunction

    task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input int glitch, input logic [9:0] exp, output logic [9:0] got);
        int w;
        logic [7:0] prev;
        logic [9:0] e;
        w    = w1 ? 1 : 8;
        prev = w1 ? last1 : last8;
        if (w1) begin a1 = a[0:0]; b1 = b[0:0]; sub1 = sub; start1 = 1'b1; end
        else    begin a8 = a;      b8 = b;      sub8 = sub; start8 = 1'b1; end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start1 = 1'b0; start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); sub1 = 1'($urandom);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            check("busy_run", w1 ? busy1 : busy8, 1);
            check("done_early", w1 ? done1 : done8, 0);
            check("sum_hold", w1 ? {7'b0, sum1} : sum8, prev);
            if (i == glitch) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; end
            if (i == glitch + 1) start8 = 1'b0;
        end
        @(negedge clk);
        start8 = 1'b0;
        check("done_pulse", w1 ? done1 : done8, 1);
        check("busy_done", w1 ? busy1 : busy8, 0);
        e   = exp_q.pop_front();
        got = w1 ? {cout1, ovf1, 7'b0, sum1} : {cout8, ovf8, sum8};
        check("result", got, e);
        if (w1) last1 = e[7:0]; else last8 = e[7:0];
        @(negedge clk);
        check("done_clear", w1 ? done1 : done8, 0);
        check("busy_idle", w1 ? busy1 : busy8, 0);
    endtask

    initial begin
        logic [9:0] got;
        logic [7:0] ra, rb;
        logic       rs, cy, s;

        rst = 1'b1; start8 = 0; start1 = 0; sub8 = 0; sub1 = 0;
        a8 = 0; b8 = 0; a1 = 0; b1 = 0;
        last8 = 0; last1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_out", {cout8, ovf8, sum8}, 0);
        check("rst_out1", {busy1, done1, cout1, ovf1, sum1}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 8'h35, 8'h4A, 0, -1, 10'h07F, got);
        run_op(0, 8'hFF, 8'h01, 0, -1, 10'h200, got);
        run_op(0, 8'h7F, 8'h01, 0, -1, 10'h180, got);
        run_op(0, 8'h10, 8'h20, 1, -1, 10'h0F0, got);
        run_op(0, 8'h80, 8'h01, 1, -1, 10'h37F, got);
        run_op(0, 8'h35, 8'h4A, 0, 2, 10'h07F, got);

        // full-adder truth table; carry-in of 1 enters through sub with B inverted
        for (int k = 0; k < 8; k++) begin
            logic fa, fb, fc;
            {fc, fa, fb} = 3'(k);
            {cy, s} = 2'(fa) + 2'(fb) + 2'(fc);
            run_op(1, {7'b0, fa}, {7'b0, fc ? ~fb : fb}, fc, -1, {cy, fc ^ cy, 7'b0, s}, got);
        end

        // reset in the middle of RUN aborts the operation
        a8 = 8'h35; b8 = 8'h4A; sub8 = 0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_out", {cout8, ovf8, sum8}, 0);
        last8 = 0; last1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_done", done8, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_done_rel", done8, 0);
        run_op(0, 8'h35, 8'h4A, 0, -1, 10'h07F, got);

        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
            run_op(0, ra, rb, rs, -1, model(8, ra, rb, rs), got);
        end
        for (int k = 0; k < 12; k++) begin
            ra = 8'($urandom_range(0, 1)); rb = 8'($urandom_range(0, 1)); rs = 1'($urandom);
            run_op(1, ra, rb, rs, -1, model(1, ra, rb, rs), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
